seq_mult_datapath: RTL and testbench

Datapath of the 16x9 sequential shift-add multiplier. It consumes the six control strobes produced by the multiplier's control ROM (LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN) and holds three registers:
- multiplicand register MX
- multiplier shift register MY
- 25-bit product accumulator ACC

A step counter qualifies the result. It raises PRODUCT_VALID after exactly MY_W accumulate steps, and flags protocol misuse through a sticky error bit.

---
 rtl/seq_mult_pkg.sv | 23 ++
 rtl/seq_mult_datapath_if.sv | 33 +++
 rtl/seq_mult_acc.sv | 54 +++++
 rtl/seq_mult_datapath.sv | 67 ++++++
 tb/tb_seq_mult_datapath.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared constants for the 16x9 sequential shift-add multiplier datapath.
// Widths, step count, and the control-ROM word bit positions.
package seq_mult_pkg;

  localparam int unsigned MX_W  = 16;          // multiplicand width
  localparam int unsigned MY_W  = 9;           // multiplier width = steps per product
  localparam int unsigned ACC_W = MX_W + MY_W; // product accumulator width
  localparam int unsigned CNT_W = 4;           // step counter width, 2^CNT_W > MY_W
  localparam int unsigned STEPS = MY_W;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEPS);

  // Control-ROM word layout; next-state field occupies [3:0].
  localparam int unsigned CW_LOAD_MX   = 9;
  localparam int unsigned CW_LOAD_MY   = 8;
  localparam int unsigned CW_SHIFT_MY  = 7;
  localparam int unsigned CW_CLEAR_ACC = 6;
  localparam int unsigned CW_LOAD_ACC  = 5;
  localparam int unsigned CW_SHIFT_IN  = 4;
  localparam int unsigned CW_NEXT_HI   = 3;
  localparam int unsigned CW_NEXT_LO   = 0;

endpackage

// File: rtl/seq_mult_datapath_if.sv
// Operand, strobe and status bundle between the multiplier control unit
// (master) and the datapath (slave).
//   MX_IN/MY_IN          operands
//   LOAD_MX..SHIFT_IN    control-ROM strobes
//   PRODUCT, PRODUCT_VALID, MY_LSB, STEP_CNT, PROTO_ERR  datapath status
interface seq_mult_datapath_if;
  import seq_mult_pkg::*;

  logic [MX_W-1:0]  MX_IN;
  logic [MY_W-1:0]  MY_IN;
  logic             LOAD_MX;
  logic             LOAD_MY;
  logic             SHIFT_MY;
  logic             CLEAR_ACC;
  logic             LOAD_ACC;
  logic             SHIFT_IN;
  logic [ACC_W-1:0] PRODUCT;
  logic             PRODUCT_VALID;
  logic             MY_LSB;
  logic [CNT_W-1:0] STEP_CNT;
  logic             PROTO_ERR;

  modport master (
    output MX_IN, MY_IN, LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN,
    input  PRODUCT, PRODUCT_VALID, MY_LSB, STEP_CNT, PROTO_ERR
  );

  modport slave (
    input  MX_IN, MY_IN, LOAD_MX, LOAD_MY, SHIFT_MY, CLEAR_ACC, LOAD_ACC, SHIFT_IN,
    output PRODUCT, PRODUCT_VALID, MY_LSB, STEP_CNT, PROTO_ERR
  );

endinterface

// File: rtl/seq_mult_acc.sv
// Product accumulator, partial-product adder and step counter.
//   clk, rst         clock, synchronous active-high reset
//   mx, my_lsb       multiplicand and current multiplier LSB
//   clear_acc, load_acc, shift_in   accumulator strobes
//   acc, step_cnt, product_valid    accumulator state and qualifier
//   overrun_err, reserved_err       protocol-misuse terms for this cycle
module seq_mult_acc
  import seq_mult_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [MX_W-1:0]  mx,
  input  logic             my_lsb,
  input  logic             clear_acc,
  input  logic             load_acc,
  input  logic             shift_in,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] step_cnt,
  output logic             product_valid,
  output logic             overrun_err,
  output logic             reserved_err
);

  logic            step_req;
  logic            step_en;
  logic [MX_W-1:0] pp;
  logic [MX_W:0]   sum;

  always_comb begin
    step_req      = load_acc && shift_in && !clear_acc;
    product_valid = (step_cnt == STEP_LAST);
    step_en       = step_req && (step_cnt < STEP_LAST);
    overrun_err   = step_req && product_valid;
    reserved_err  = load_acc && !shift_in && !clear_acc;
    pp            = my_lsb ? mx : '0;
    // Upper MX_W bits plus partial product, kept at MX_W+1 bits so the carry
    // lands in the accumulator MSB.
    sum           = {1'b0, acc[ACC_W-1:MY_W]} + {1'b0, pp};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      step_cnt <= '0;
    end else if (clear_acc) begin
      acc      <= '0;
      step_cnt <= '0;
    end else if (step_en) begin
      acc      <= {sum, acc[MY_W-1:1]};
      step_cnt <= step_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_mult_datapath.sv
// Datapath of the 16x9 sequential shift-add multiplier: multiplicand
// register, multiplier shift register, sticky protocol-error flag, and the
// accumulator sub-block.
//   CLK, RST   clock, synchronous active-high reset
//   bus        operands/strobes in, product and status out (slave side)
module seq_mult_datapath
  import seq_mult_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  seq_mult_datapath_if.slave  bus
);

  logic [MX_W-1:0]  mx;
  logic [MY_W-1:0]  my;
  logic             proto_err;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] step_cnt;
  logic             product_valid;
  logic             overrun_err;
  logic             reserved_err;
  logic             midload_err;

  seq_mult_acc u_acc (
    .clk           (CLK),
    .rst           (RST),
    .mx            (mx),
    .my_lsb        (my[0]),
    .clear_acc     (bus.CLEAR_ACC),
    .load_acc      (bus.LOAD_ACC),
    .shift_in      (bus.SHIFT_IN),
    .acc           (acc),
    .step_cnt      (step_cnt),
    .product_valid (product_valid),
    .overrun_err   (overrun_err),
    .reserved_err  (reserved_err)
  );

  // Reloading an operand part-way through a product corrupts it; a load that
  // coincides with CLEAR_ACC is a normal start and is not flagged.
  always_comb begin
    midload_err = (bus.LOAD_MX || bus.LOAD_MY) && !bus.CLEAR_ACC &&
                  (step_cnt != '0) && (step_cnt < STEP_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mx        <= '0;
      my        <= '0;
      proto_err <= 1'b0;
    end else begin
      if (bus.LOAD_MX) mx <= bus.MX_IN;
      if (bus.LOAD_MY)       my <= bus.MY_IN;
      else if (bus.SHIFT_MY) my <= {1'b0, my[MY_W-1:1]};
      if (overrun_err || reserved_err || midload_err) proto_err <= 1'b1;
    end
  end

  always_comb begin
    bus.PRODUCT       = acc;
    bus.PRODUCT_VALID = product_valid;
    bus.MY_LSB        = my[0];
    bus.STEP_CNT      = step_cnt;
    bus.PROTO_ERR     = proto_err;
  end

endmodule

// File: tb/tb_seq_mult_datapath.sv
// Directed self-checking bench for seq_mult_datapath.
module tb_seq_mult_datapath;
  import seq_mult_pkg::*;

  logic clk;
  logic rst;
  int unsigned n_checks;
  int unsigned n_fail;

  seq_mult_datapath_if bus ();

  seq_mult_datapath dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [9:0] CW_IDLE  = 10'd0;
  localparam logic [9:0] CW_START = (10'd1 << CW_LOAD_MX) | (10'd1 << CW_LOAD_MY) |
                                    (10'd1 << CW_CLEAR_ACC);
  localparam logic [9:0] CW_STEP  = (10'd1 << CW_SHIFT_MY) | (10'd1 << CW_LOAD_ACC) |
                                    (10'd1 << CW_SHIFT_IN);
  localparam logic [9:0] CW_CLEAR = 10'd1 << CW_CLEAR_ACC;
  localparam logic [9:0] CW_RSVD  = 10'd1 << CW_LOAD_ACC;
  localparam logic [9:0] CW_SIN   = 10'd1 << CW_SHIFT_IN;
  localparam logic [9:0] CW_LDMX  = 10'd1 << CW_LOAD_MX;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one control word for a single rising edge, then drop the strobes.
  task automatic issue(input logic [9:0] cw);
    bus.LOAD_MX   = cw[CW_LOAD_MX];
    bus.LOAD_MY   = cw[CW_LOAD_MY];
    bus.SHIFT_MY  = cw[CW_SHIFT_MY];
    bus.CLEAR_ACC = cw[CW_CLEAR_ACC];
    bus.LOAD_ACC  = cw[CW_LOAD_ACC];
    bus.SHIFT_IN  = cw[CW_SHIFT_IN];
    @(posedge clk);
    #1;
    bus.LOAD_MX   = 1'b0;
    bus.LOAD_MY   = 1'b0;
    bus.SHIFT_MY  = 1'b0;
    bus.CLEAR_ACC = 1'b0;
    bus.LOAD_ACC  = 1'b0;
    bus.SHIFT_IN  = 1'b0;
  endtask

  // Reset is applied together with step strobes to show it dominates them.
  task automatic do_reset();
    rst = 1'b1;
    issue(CW_STEP);
    rst = 1'b0;
  endtask

  task automatic start(input logic [15:0] a, input logic [8:0] b);
    bus.MX_IN = a;
    bus.MY_IN = b;
    issue(CW_START);
  endtask

  task automatic run_steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) issue(CW_STEP);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_product"}, 32'(bus.PRODUCT), 32'h0);
    check_eq({tag, "_valid"},   32'(bus.PRODUCT_VALID), 32'h0);
    check_eq({tag, "_my_lsb"},  32'(bus.MY_LSB), 32'h0);
    check_eq({tag, "_step_cnt"}, 32'(bus.STEP_CNT), 32'h0);
    check_eq({tag, "_proto_err"}, 32'(bus.PROTO_ERR), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.MX_IN = '0;
    bus.MY_IN = '0;
    bus.LOAD_MX = 1'b0; bus.LOAD_MY = 1'b0; bus.SHIFT_MY = 1'b0;
    bus.CLEAR_ACC = 1'b0; bus.LOAD_ACC = 1'b0; bus.SHIFT_IN = 1'b0;

    do_reset();
    check_all_zero("reset");

    // Basic product 0x1234 * 0x0AB = 0x0C28BC
    start(16'h1234, 9'h0AB);
    check_eq("start_cnt", 32'(bus.STEP_CNT), 32'd0);
    check_eq("start_lsb", 32'(bus.MY_LSB), 32'd1);
    run_steps(8);
    check_eq("step8_valid", 32'(bus.PRODUCT_VALID), 32'd0);
    check_eq("step8_cnt", 32'(bus.STEP_CNT), 32'd8);
    run_steps(1);
    check_eq("basic_product", 32'(bus.PRODUCT), 32'h0C28BC);
    check_eq("basic_valid", 32'(bus.PRODUCT_VALID), 32'd1);
    check_eq("basic_cnt", 32'(bus.STEP_CNT), 32'd9);
    check_eq("basic_err", 32'(bus.PROTO_ERR), 32'd0);

    // Idle hold and SHIFT_IN without LOAD_ACC
    issue(CW_IDLE); issue(CW_IDLE); issue(CW_SIN);
    check_eq("idle_product", 32'(bus.PRODUCT), 32'h0C28BC);
    check_eq("idle_valid", 32'(bus.PRODUCT_VALID), 32'd1);
    check_eq("sin_only_err", 32'(bus.PROTO_ERR), 32'd0);

    // Overrun, then clear keeps the sticky error
    issue(CW_STEP);
    check_eq("ovr_product", 32'(bus.PRODUCT), 32'h0C28BC);
    check_eq("ovr_cnt", 32'(bus.STEP_CNT), 32'd9);
    check_eq("ovr_err", 32'(bus.PROTO_ERR), 32'd1);
    issue(CW_CLEAR);
    check_eq("clr_product", 32'(bus.PRODUCT), 32'h0);
    check_eq("clr_valid", 32'(bus.PRODUCT_VALID), 32'd0);
    check_eq("clr_err", 32'(bus.PROTO_ERR), 32'd1);

    // Maximum operands
    do_reset();
    start(16'hFFFF, 9'h1FF);
    run_steps(9);
    check_eq("max_product", 32'(bus.PRODUCT), 32'h1FEFE01);
    check_eq("max_err", 32'(bus.PROTO_ERR), 32'd0);

    // Zero operands
    start(16'h0000, 9'h1FF);
    run_steps(9);
    check_eq("zero_mx_product", 32'(bus.PRODUCT), 32'h0);
    start(16'hFFFF, 9'h000);
    check_eq("zero_my_lsb_start", 32'(bus.MY_LSB), 32'd0);
    for (int unsigned i = 0; i < 9; i++) begin
      issue(CW_STEP);
      check_eq("zero_my_lsb", 32'(bus.MY_LSB), 32'd0);
    end
    check_eq("zero_my_product", 32'(bus.PRODUCT), 32'h0);
    check_eq("zero_my_valid", 32'(bus.PRODUCT_VALID), 32'd1);

    // Reserved mode at step 4: partial = (0x1234*0xB) << 5 = 0x190780
    start(16'h1234, 9'h0AB);
    run_steps(4);
    check_eq("part4_product", 32'(bus.PRODUCT), 32'h190780);
    issue(CW_RSVD);
    check_eq("rsvd_product", 32'(bus.PRODUCT), 32'h190780);
    check_eq("rsvd_cnt", 32'(bus.STEP_CNT), 32'd4);
    check_eq("rsvd_err", 32'(bus.PROTO_ERR), 32'd1);
    run_steps(5);
    check_eq("rsvd_resume_product", 32'(bus.PRODUCT), 32'h0C28BC);

    // Reset mid-multiply, then a fresh 3*5
    start(16'h1234, 9'h0AB);
    run_steps(5);
    do_reset();
    check_all_zero("midrst");
    start(16'h0003, 9'h005);
    run_steps(9);
    check_eq("small_product", 32'(bus.PRODUCT), 32'h0F);
    check_eq("small_err", 32'(bus.PROTO_ERR), 32'd0);

    // Operand reload mid-product flags an error; counter continues
    start(16'h0003, 9'h005);
    run_steps(2);
    bus.MX_IN = 16'h0007;
    issue(CW_LDMX);
    check_eq("midload_err", 32'(bus.PROTO_ERR), 32'd1);
    check_eq("midload_cnt", 32'(bus.STEP_CNT), 32'd2);
    run_steps(1);
    check_eq("midload_cnt_next", 32'(bus.STEP_CNT), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
